// File: rtl/ram_arbiter_pkg.sv
// Shared types for the RAM arbiter: word type, grant-state encoding and default starvation limit.
package ram_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    GNT_D,
    GNT_I0,
    GNT_I1
  } arb_state_t;

  localparam int unsigned DSTARVE_DEFAULT = 4;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the data-port, icache and RAM-side signals around the RAM arbiter.
interface ram_arbiter_if;
  import ram_arbiter_pkg::*;

  logic        dREN;
  logic        dWEN;
  logic        dlock;
  word_t       daddr;
  word_t       dstore;
  logic        dwait;
  word_t       dload;

  logic  [1:0] iREN;
  word_t [1:0] iaddr;
  logic  [1:0] iwait;
  word_t [1:0] iload;

  logic        ramREN;
  logic        ramWEN;
  word_t       ramaddr;
  word_t       ramstore;
  word_t       ramload;
  logic        ramwait;

  // Arbiter view
  modport slave (
    input  dREN, dWEN, dlock, daddr, dstore, iREN, iaddr, ramload, ramwait,
    output dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
  );

  // Requesters and RAM view
  modport master (
    output dREN, dWEN, dlock, daddr, dstore, iREN, iaddr, ramload, ramwait,
    input  dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/ram_arbiter_rr.sv
// Round-robin pointer, data-starvation counter and IDLE pick logic; grant is one-hot {I1, I0, D}.
module ram_arbiter_rr #(
  parameter int unsigned DSTARVE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       idle,
  input  logic       dreq,
  input  logic [1:0] ireq,
  input  logic       d_done,
  input  logic [1:0] i_done,
  output logic [2:0] grant
);

  localparam int unsigned CW = (DSTARVE < 1) ? 1 : $clog2(DSTARVE + 1);
  localparam logic [CW-1:0] DMAX = CW'(DSTARVE);

  logic          rr_ptr;
  logic [CW-1:0] dcount;
  logic          starve;
  logic [1:0]    ipick;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
      dcount <= '0;
    end else if (i_done[0]) begin
      rr_ptr <= 1'b1;
      dcount <= '0;
    end else if (i_done[1]) begin
      rr_ptr <= 1'b0;
      dcount <= '0;
    end else if (d_done && (|ireq) && (dcount != DMAX)) begin
      dcount <= dcount + 1'b1;
    end else if (idle && !(|ireq)) begin
      dcount <= '0;
    end
  end

  always_comb begin
    ipick  = '0;
    starve = (|ireq) && (dcount == DMAX);
    if (ireq[rr_ptr]) begin
      ipick[rr_ptr] = 1'b1;
    end else if (ireq[~rr_ptr]) begin
      ipick[~rr_ptr] = 1'b1;
    end
    grant = '0;
    // Starvation implies an icache is pending, so ipick is never empty when it wins.
    if (idle) begin
      grant = (dreq && !starve) ? 3'b001 : {ipick, 1'b0};
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port RAM between the data port (priority) and two round-robin icaches.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned DSTARVE = DSTARVE_DEFAULT
) (
  input logic        CLK,
  input logic        RST,
  ram_arbiter_if.slave bus
);

  arb_state_t state;
  arb_state_t next_state;
  logic [2:0] grant;
  logic       dreq;
  logic       d_done;
  logic [1:0] i_done;

  assign dreq      = bus.dREN | bus.dWEN;
  assign d_done    = (state == GNT_D)  && !bus.ramwait;
  assign i_done[0] = (state == GNT_I0) && !bus.ramwait;
  assign i_done[1] = (state == GNT_I1) && !bus.ramwait;

  ram_arbiter_rr #(.DSTARVE(DSTARVE)) u_rr (
    .clk    (CLK),
    .rst    (RST),
    .idle   (state == IDLE),
    .dreq   (dreq),
    .ireq   (bus.iREN),
    .d_done (d_done),
    .i_done (i_done),
    .grant  (grant)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant[0])      next_state = GNT_D;
        else if (grant[1]) next_state = GNT_I0;
        else if (grant[2]) next_state = GNT_I1;
      end
      GNT_D: begin
        if (!bus.ramwait)  next_state = bus.dlock ? GNT_D : IDLE;
        else if (!dreq)    next_state = IDLE;
      end
      GNT_I0: if (!bus.ramwait || !bus.iREN[0]) next_state = IDLE;
      GNT_I1: if (!bus.ramwait || !bus.iREN[1]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.dwait    = 1'b1;
    bus.dload    = '0;
    bus.iwait    = '1;
    bus.iload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    // RAM side follows the granted requester live; reset drops everything in the same cycle.
    if (!RST) begin
      case (state)
        GNT_D: begin
          bus.ramREN   = bus.dREN & ~bus.dWEN;
          bus.ramWEN   = bus.dWEN;
          bus.ramaddr  = bus.daddr;
          bus.ramstore = bus.dstore;
          bus.dload    = bus.ramload;
          bus.dwait    = bus.ramwait;
        end
        GNT_I0: begin
          bus.ramREN   = bus.iREN[0];
          bus.ramaddr  = bus.iaddr[0];
          bus.iload[0] = bus.ramload;
          bus.iwait[0] = bus.ramwait;
        end
        GNT_I1: begin
          bus.ramREN   = bus.iREN[1];
          bus.ramaddr  = bus.iaddr[1];
          bus.iload[1] = bus.ramload;
          bus.iwait[1] = bus.ramwait;
        end
        default: ;
      endcase
    end
  end

endmodule
